// File: rtl/axis2ccd_pkg.sv
// Shared types and constants for the AXIS-to-CCD line converter.
package axis2ccd_pkg;

  // Width of the reader column counter and of the stored per-bank pixel counts.
  localparam int COL_W = 13;

  // Reader states: inter-line gap, leading dummies, stored pixels, trailing dummies.
  typedef enum logic [1:0] {
    RD_GAP    = 2'd0,
    RD_PRE    = 2'd1,
    RD_EFFECT = 2'd2,
    RD_POST   = 2'd3
  } rd_state_e;

  // Writer states: storing a line, or dropping the tail of an over-long line.
  typedef enum logic {
    WR_WRITE   = 1'b0,
    WR_DISCARD = 1'b1
  } wr_state_e;

  // Column-address width for one bank; never below one bit.
  function automatic int col_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis2ccd_line_ram.sv
// Two-bank line buffer: simple dual-port RAM, bank chosen by the address MSB,
// one-cycle registered read.
module axis2ccd_line_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port and registered read port; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis2ccd.sv
// AXI4-Stream video in, fixed-rate CCD-style line bursts out.
// A writer fills one of two line banks from the stream; a reader FSM plays a
// full bank out as PRE dummies, EFFECT pixels and POST dummies, separated by
// at least GAP idle cycles.
//
// Handshake: an input beat transfers on a rising edge where s_axis_tvalid and
// s_axis_tready are both high. s_axis_tready is high while the write bank is
// free; in DISCARD it is also high for non-tuser beats (they are dropped), but
// a tuser beat is held off until the write bank is free, because it has to be
// stored as beat 0 of a new line.
module axis2ccd
  import axis2ccd_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    EFFECT_COLS     = 2048,
  parameter int                    PRE_DUMMY_COLS  = 32,
  parameter int                    POST_DUMMY_COLS = 8,
  parameter int                    GAP_COLS        = 4,
  parameter logic [DATA_WIDTH-1:0] DUMMY_VALUE     = '0
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  tvalid,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  sof,
  output logic                  err_short,
  output logic                  err_long
);

  localparam int CW     = col_addr_w(EFFECT_COLS);
  localparam int ADDR_W = CW + 1;

  localparam logic [COL_W-1:0] EFF_N  = COL_W'(EFFECT_COLS);
  localparam logic [COL_W-1:0] PRE_N  = COL_W'(PRE_DUMMY_COLS);
  localparam logic [COL_W-1:0] POST_N = COL_W'(POST_DUMMY_COLS);
  localparam logic [COL_W-1:0] GAP_N  = COL_W'(GAP_COLS);
  localparam logic [COL_W-1:0] ONE    = COL_W'(1);

  // ---------------- shared bank status ----------------
  logic [1:0]            full_q, full_d;
  logic [1:0][COL_W-1:0] cnt_q, cnt_d;
  logic [1:0]            sof_flag_q, sof_flag_d;

  // ---------------- writer ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [COL_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  sof_cur_q, sof_cur_d;
  logic                  rdy_en_q, rdy_en_d;
  logic                  err_short_p_q, err_short_p_d;
  logic                  err_long_p_q, err_long_p_d;
  logic                  err_short_q, err_short_d;
  logic                  err_long_q, err_long_d;
  logic                  acc, store, wr_close;
  logic [COL_W-1:0]      beat_idx, beat_n;
  logic                  beat_sof;

  // ---------------- reader ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [COL_W-1:0]      cols_q, cols_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  rd_free;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  sof_q, sof_d;
  logic [CW-1:0]         rd_col;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign s_axis_tready = rdy_en_q &
                         (!full_q[wr_bank_q] ||
                          ((wr_state_q == WR_DISCARD) && !s_axis_tuser));
  assign acc = s_axis_tvalid && s_axis_tready;

  // Writer: place accepted beats, close banks on tlast or a full line, flag errors.
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_bank_d     = wr_bank_q;
    wr_cnt_d      = wr_cnt_q;
    sof_cur_d     = sof_cur_q;
    cnt_d         = cnt_q;
    sof_flag_d    = sof_flag_q;
    rdy_en_d      = 1'b1;
    err_short_p_d = 1'b0;
    err_long_p_d  = 1'b0;
    err_short_d   = err_short_p_q;
    err_long_d    = err_long_p_q;
    wr_close      = 1'b0;
    // A tuser beat always restarts the line at address 0.
    beat_idx      = s_axis_tuser ? '0 : wr_cnt_q;
    beat_n        = beat_idx + ONE;
    beat_sof      = s_axis_tuser || ((wr_cnt_q != '0) && sof_cur_q);
    store         = acc && ((wr_state_q == WR_WRITE) || s_axis_tuser);

    if (acc && (wr_state_q == WR_DISCARD) && !s_axis_tuser && s_axis_tlast) begin
      wr_state_d = WR_WRITE;
    end

    if (store) begin
      wr_state_d = WR_WRITE;
      if (s_axis_tlast || (beat_n == EFF_N)) begin
        wr_close              = 1'b1;
        cnt_d[wr_bank_q]      = beat_n;
        sof_flag_d[wr_bank_q] = beat_sof;
        wr_bank_d             = ~wr_bank_q;
        wr_cnt_d              = '0;
        sof_cur_d             = 1'b0;
        if (s_axis_tlast) begin
          err_short_p_d = (beat_n < EFF_N);
        end else begin
          err_long_p_d = 1'b1;
          wr_state_d   = WR_DISCARD;
        end
      end else begin
        wr_cnt_d  = beat_n;
        sof_cur_d = beat_sof;
      end
    end
  end

  // Reader: walk GAP -> PRE -> EFFECT -> POST; outputs trail the state by one cycle.
  always_comb begin
    rd_state_d = rd_state_q;
    cols_d     = cols_q;
    rd_bank_d  = rd_bank_q;
    rd_free    = 1'b0;
    case (rd_state_q)
      RD_GAP: begin
        if (cols_q >= GAP_N - ONE) begin
          if (full_q[rd_bank_q]) begin
            rd_state_d = RD_PRE;
            cols_d     = '0;
          end
        end else begin
          cols_d = cols_q + ONE;
        end
      end
      RD_PRE: begin
        if (cols_q == PRE_N - ONE) begin
          rd_state_d = RD_EFFECT;
          cols_d     = '0;
        end else begin
          cols_d = cols_q + ONE;
        end
      end
      RD_EFFECT: begin
        if (cols_q == EFF_N - ONE) begin
          rd_state_d = RD_POST;
          cols_d     = '0;
        end else begin
          cols_d = cols_q + ONE;
        end
      end
      RD_POST: begin
        if (cols_q == POST_N - ONE) begin
          rd_state_d = RD_GAP;
          cols_d     = '0;
          rd_free    = 1'b1;
          rd_bank_d  = ~rd_bank_q;
        end else begin
          cols_d = cols_q + ONE;
        end
      end
      default: begin
        rd_state_d = RD_GAP;
        cols_d     = '0;
      end
    endcase

    // Address 0 is fetched on the last PRE cycle, then one ahead during EFFECT.
    rd_col   = (rd_state_q == RD_PRE) ? '0 : CW'(cols_q + ONE);
    tvalid_d = (rd_state_q != RD_GAP);
    sof_d    = (rd_state_q == RD_PRE) && (cols_q == '0) && sof_flag_q[rd_bank_q];
    tdata_d  = ((rd_state_q == RD_EFFECT) && (cols_q < cnt_q[rd_bank_q])) ?
               ram_rdata : DUMMY_VALUE;
  end

  // Full flags: writer sets the bank it closes, reader clears the bank it finished.
  always_comb begin
    full_d = full_q;
    if (rd_free) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_close) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  // Writer and bank-status registers.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q    <= WR_WRITE;
      wr_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      sof_cur_q     <= 1'b0;
      rdy_en_q      <= 1'b0;
      err_short_p_q <= 1'b0;
      err_long_p_q  <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      full_q        <= '0;
      cnt_q         <= '0;
      sof_flag_q    <= '0;
    end else begin
      wr_state_q    <= wr_state_d;
      wr_bank_q     <= wr_bank_d;
      wr_cnt_q      <= wr_cnt_d;
      sof_cur_q     <= sof_cur_d;
      rdy_en_q      <= rdy_en_d;
      err_short_p_q <= err_short_p_d;
      err_long_p_q  <= err_long_p_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      full_q        <= full_d;
      cnt_q         <= cnt_d;
      sof_flag_q    <= sof_flag_d;
    end
  end

  // Reader FSM with its registered CCD outputs.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_GAP;
      cols_q     <= '0;
      rd_bank_q  <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      sof_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      cols_q     <= cols_d;
      rd_bank_q  <= rd_bank_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      sof_q      <= sof_d;
    end
  end

  axis2ccd_line_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_line_ram (
    .clk   (pixel_clk),
    .we    (store),
    .waddr ({wr_bank_q, beat_idx[CW-1:0]}),
    .wdata (s_axis_tdata),
    .raddr ({rd_bank_q, rd_col}),
    .rdata (ram_rdata)
  );

  assign tvalid    = tvalid_q;
  assign tdata     = tdata_q;
  assign sof       = sof_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

// File: tb/tb_axis2ccd.sv
// Directed bench for axis2ccd with EFFECT=8, PRE=2, POST=1, GAP=3.
module tb_axis2ccd;

  localparam int EC    = 8;
  localparam int PRE   = 2;
  localparam int POST  = 1;
  localparam int GAP   = 3;
  localparam int BURST = PRE + EC + POST;

  logic       pixel_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tready;
  logic       tvalid;
  logic [7:0] tdata;
  logic       sof;
  logic       err_short;
  logic       err_long;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_cnt = 0;

  logic [8:0] out_q[$];
  logic [8:0] exp_q[$];
  int         len_q[$];
  int         gap_q[$];
  int         rise_q[$];
  int         run_len = 0;
  int         low_len = 0;
  logic       prev_tv = 1'b0;
  int         es_cnt = 0, el_cnt = 0, es_cyc = -1, el_cyc = -1;
  int         acc_cyc[16];

  axis2ccd #(
    .DATA_WIDTH      (8),
    .EFFECT_COLS     (EC),
    .PRE_DUMMY_COLS  (PRE),
    .POST_DUMMY_COLS (POST),
    .GAP_COLS        (GAP),
    .DUMMY_VALUE     (8'd0)
  ) dut (
    .pixel_clk     (pixel_clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .tvalid        (tvalid),
    .tdata         (tdata),
    .sof           (sof),
    .err_short     (err_short),
    .err_long      (err_long)
  );

  // ---------------- clock / reset ----------------
  always #5 pixel_clk = ~pixel_clk;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- output monitor ----------------
  always @(negedge pixel_clk) begin
    if (tvalid) begin
      if (!prev_tv) begin
        gap_q.push_back(low_len);
        rise_q.push_back(cyc);
        run_len = 0;
      end
      out_q.push_back({sof, tdata});
      run_len++;
    end else begin
      if (prev_tv) begin
        len_q.push_back(run_len);
        low_len = 0;
      end
      low_len++;
    end
    prev_tv = tvalid;
    if (err_short) begin es_cnt++; es_cyc = cyc; end
    if (err_long)  begin el_cnt++; el_cyc = cyc; end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected burst: two dummies, EC effect pixels (start.. for n, then 0), one dummy.
  task automatic push_burst(input logic s, input int start, input int n);
    exp_q.push_back({s, 8'd0});
    exp_q.push_back({1'b0, 8'd0});
    for (int i = 0; i < EC; i++) begin
      exp_q.push_back({1'b0, (i < n) ? 8'(start + i) : 8'd0});
    end
    exp_q.push_back({1'b0, 8'd0});
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check($sformatf("%s_px%0d", tag, i), out_q[i], exp_q[i]);
    end
    foreach (len_q[i]) check($sformatf("%s_len%0d", tag, i), len_q[i], BURST);
    foreach (gap_q[i]) check($sformatf("%s_gap%0d", tag, i), gap_q[i] >= GAP, 1);
    out_q.delete(); exp_q.delete(); len_q.delete(); gap_q.delete(); rise_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the beat transfers.
  task automatic send_beat(input logic [7:0] d, input logic u, input logic l, output int acc);
    bit done;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      #1;
      if (s_axis_tready) done = 1'b1;
      else stall_cnt++;
      @(negedge pixel_clk);
    end
    acc = cyc;
    if (!done) check("beat_accept_timeout", done, 1);
  endtask

  task automatic send_line(input int start, input int n, input bit u0, input bit lst,
                           output int end_cyc);
    for (int i = 0; i < n; i++) begin
      send_beat(8'(start + i), u0 && (i == 0), lst && (i == n - 1), acc_cyc[i]);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    end_cyc = acc_cyc[n - 1];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e1, e2, rel_cyc, tmp;

    // Reset state
    #1 rst_n = 1'b0;
    idle(3);
    check("rst_tvalid", tvalid, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_tdata", tdata, 0);
    check("rst_sof", sof, 0);
    check("rst_errs", {err_short, err_long}, 0);
    rst_n = 1'b1;
    #1 check("rel_tready_before_edge", s_axis_tready, 0);
    idle(1);
    check("rel_tready_after_edge", s_axis_tready, 1);
    idle(5);
    out_q.delete(); len_q.delete(); gap_q.delete(); rise_q.delete();

    // Nominal frame: two lines
    es_cnt = 0; el_cnt = 0;
    send_line(1, 8, 1, 1, e1);
    send_line(9, 8, 0, 1, e2);
    idle(60);
    check("nom_latency", (rise_q.size() > 0) ? rise_q[0] - e1 : -1, 2);
    check("nom_err_short", es_cnt, 0);
    check("nom_err_long", el_cnt, 0);
    push_burst(1, 1, 8);
    push_burst(0, 9, 8);
    check_stream("nom");

    // Short line
    es_cnt = 0; el_cnt = 0;
    send_line(1, 5, 1, 1, e1);
    idle(40);
    check("short_pulses", es_cnt, 1);
    check("short_pulse_time", es_cyc - e1, 1);
    check("short_no_long", el_cnt, 0);
    push_burst(1, 1, 5);
    check_stream("short");

    // Long line, then a normal line
    es_cnt = 0; el_cnt = 0; stall_cnt = 0;
    send_line(1, 12, 1, 1, e1);
    check("long_no_stall", stall_cnt, 0);
    tmp = acc_cyc[7];
    send_line(21, 8, 0, 1, e2);
    idle(60);
    check("long_pulses", el_cnt, 1);
    check("long_pulse_time", el_cyc - tmp, 1);
    check("long_no_short", es_cnt, 0);
    push_burst(1, 1, 8);
    push_burst(0, 21, 8);
    check_stream("long");

    // Backpressure: three lines with tvalid held high
    stall_cnt = 0;
    send_line(31, 8, 1, 1, e1);
    send_line(41, 8, 0, 1, e1);
    send_line(51, 8, 0, 1, e1);
    check("bp_stalled", stall_cnt > 0, 1);
    idle(80);
    push_burst(1, 31, 8);
    push_burst(0, 41, 8);
    push_burst(0, 51, 8);
    check_stream("bp");

    // Mid-line tuser restarts the line
    es_cnt = 0; el_cnt = 0;
    send_line(61, 8, 1, 1, e1);
    send_line(71, 3, 0, 0, e1);
    send_line(80, 8, 1, 1, e1);
    idle(60);
    check("mid_no_errs", es_cnt + el_cnt, 0);
    push_burst(1, 61, 8);
    push_burst(1, 80, 8);
    check_stream("mid");

    // Reset in the middle of a burst with a second line buffered
    send_line(91, 8, 1, 1, e1);
    tmp = 0;
    for (int k = 0; k < 50 && !tmp; k++) begin
      if (tvalid) tmp = 1;
      else @(negedge pixel_clk);
    end
    check("rst_burst_started", tmp, 1);
    send_line(101, 8, 0, 1, e2);
    check("rst_pre_tvalid", tvalid, 1);
    check("rst_pre_tdata", tdata, 97);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid", tvalid, 0);
    check("rst_mid_tready", s_axis_tready, 0);
    idle(3);
    rst_n = 1'b1;
    rel_cyc = cyc;
    idle(2);
    out_q.delete(); len_q.delete(); gap_q.delete(); rise_q.delete();
    idle(40);
    check("rst_no_stale_output", out_q.size(), 0);
    send_line(111, 8, 1, 1, e1);
    idle(60);
    check("rst_first_rise_delay",
          (rise_q.size() > 0) ? (rise_q[0] - rel_cyc >= 3) : 0, 1);
    push_burst(1, 111, 8);
    check_stream("rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
